// File: rtl/imm_decode_stage.sv
// Registered RV32I/RV64I immediate-decode stage with valid/ready handshake and optional skid entry.
// Optional feature macro: ZICSR_EN (CSR immediate forms decode as fmt Z with a zero-extended uimm).
module imm_decode_stage #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_R    = 3'd6;
    localparam logic [2:0] FMT_Z    = 3'd7;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [31:0]     imm_i32;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign imm_i32  = {{20{in_instr[31]}}, in_instr[31:20]};

    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                dec_fmt = FMT_I;
                dec_imm = sext32(imm_i32);
            end
            OPC_OP_IMM: begin
                dec_fmt = FMT_I;
                if (is_shift) begin
                    if (XLEN == 64) begin
                        dec_imm = XLEN'(in_instr[25:20]);
                    end else begin
                        dec_imm     = XLEN'(in_instr[24:20]);
                        dec_illegal = in_instr[25];
                    end
                end else begin
                    dec_imm = sext32(imm_i32);
                end
            end
            OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_I;
                    dec_imm = is_shift ? XLEN'(in_instr[24:20]) : sext32(imm_i32);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
            end
            OPC_BRANCH: begin
                dec_fmt = FMT_B;
                dec_imm = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0});
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_fmt = FMT_U;
                dec_imm = sext32({in_instr[31:12], 12'b0});
            end
            OPC_JAL: begin
                dec_fmt = FMT_J;
                dec_imm = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0});
            end
            OPC_OP: begin
                dec_fmt = FMT_R;
            end
            OPC_OP32: begin
                if (XLEN == 64) begin
                    dec_fmt = FMT_R;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                dec_fmt = FMT_NONE;
            end
            OPC_SYSTEM: begin
`ifdef ZICSR_EN
                if (funct3[2]) begin
                    dec_fmt = FMT_Z;
                    dec_imm = XLEN'(in_instr[19:15]);
                end
`else
                dec_fmt = FMT_NONE;
`endif
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output register and skid entry
    // ------------------------------------------------------------------
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic [2:0]      out_fmt_q, out_fmt_d;
    logic            out_illegal_q, out_illegal_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;

    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [2:0]      skid_fmt_q, skid_fmt_d;
    logic            skid_illegal_q, skid_illegal_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    logic in_ready_w;
    logic accept;
    logic out_free;

    // With the skid entry, in_ready comes straight from a flop so out_ready never reaches upstream.
    assign in_ready_w = (SKID != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready_w && !flush;
    assign out_free   = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_fmt_d      = out_fmt_q;
        out_illegal_d  = out_illegal_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_fmt_d     = skid_fmt_q;
        skid_illegal_d = skid_illegal_q;
        skid_instr_d   = skid_instr_q;
        skid_pc_d      = skid_pc_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            // The skid entry is always older than anything on the input, so it goes first.
            if (skid_valid_q) begin
                out_valid_d   = 1'b1;
                out_imm_d     = skid_imm_q;
                out_fmt_d     = skid_fmt_q;
                out_illegal_d = skid_illegal_q;
                out_instr_d   = skid_instr_q;
                out_pc_d      = skid_pc_q;
                skid_valid_d  = 1'b0;
            end else if (accept) begin
                out_valid_d   = 1'b1;
                out_imm_d     = dec_imm;
                out_fmt_d     = dec_fmt;
                out_illegal_d = dec_illegal;
                out_instr_d   = in_instr;
                out_pc_d      = in_pc;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept && (SKID != 0)) begin
            skid_valid_d   = 1'b1;
            skid_imm_d     = dec_imm;
            skid_fmt_d     = dec_fmt;
            skid_illegal_d = dec_illegal;
            skid_instr_d   = in_instr;
            skid_pc_d      = in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_fmt_q      <= FMT_NONE;
            out_illegal_q  <= 1'b0;
            out_instr_q    <= '0;
            out_pc_q       <= '0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_fmt_q     <= FMT_NONE;
            skid_illegal_q <= 1'b0;
            skid_instr_q   <= '0;
            skid_pc_q      <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_fmt_q      <= out_fmt_d;
            out_illegal_q  <= out_illegal_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_fmt_q     <= skid_fmt_d;
            skid_illegal_q <= skid_illegal_d;
            skid_instr_q   <= skid_instr_d;
            skid_pc_q      <= skid_pc_d;
        end
    end

    assign in_ready    = in_ready_w;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_illegal_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed self-checking bench for imm_decode_stage (XLEN=32, SKID=1).
module tb_imm_decode_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;

    int checks = 0;
    int errors = 0;

    imm_decode_stage #(.XLEN(XLEN), .SKID(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_fmt    (out_fmt),
        .out_illegal(out_illegal),
        .out_instr  (out_instr),
        .out_pc     (out_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== '0 || out_fmt !== 3'd0 ||
            out_illegal !== 1'b0 || out_instr !== '0 || out_pc !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b imm=%h fmt=%0d ill=%b instr=%h pc=%h, want all zero with ready=1",
                     out_valid, in_ready, out_imm, out_fmt, out_illegal, out_instr, out_pc);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_formats();
        logic [31:0] vin   [15];
        logic [31:0] vimm  [15];
        logic [2:0]  vfmt  [15];
        logic        vill  [15];
        logic [2:0]  zfmt;
        logic [31:0] zimm;
`ifdef ZICSR_EN
        zfmt = 3'd7; zimm = 32'h0000001F;
`else
        zfmt = 3'd0; zimm = 32'h0;
`endif
        vin[0]  = 32'hFFC12083; vimm[0]  = 32'hFFFFFFFC; vfmt[0]  = 3'd1; vill[0]  = 1'b0; // lw x1,-4(x2)
        vin[1]  = 32'hFE000CE3; vimm[1]  = 32'hFFFFFFF8; vfmt[1]  = 3'd3; vill[1]  = 1'b0; // beq x0,x0,-8
        vin[2]  = 32'hFE000C63; vimm[2]  = 32'hFFFFF7F8; vfmt[2]  = 3'd3; vill[2]  = 1'b0; // B with instr[7]=0
        vin[3]  = 32'h123452B7; vimm[3]  = 32'h12345000; vfmt[3]  = 3'd4; vill[3]  = 1'b0; // lui
        vin[4]  = 32'h001000EF; vimm[4]  = 32'h00000800; vfmt[4]  = 3'd5; vill[4]  = 1'b0; // jal x1,2048
        vin[5]  = 32'h0000007F; vimm[5]  = 32'h0;        vfmt[5]  = 3'd0; vill[5]  = 1'b1; // bad opcode
        vin[6]  = 32'h02009093; vimm[6]  = 32'h0;        vfmt[6]  = 3'd1; vill[6]  = 1'b1; // slli shamt[5]=1
        vin[7]  = 32'h00309093; vimm[7]  = 32'h00000003; vfmt[7]  = 3'd1; vill[7]  = 1'b0; // slli x1,x1,3
        vin[8]  = 32'h41F0D093; vimm[8]  = 32'h0000001F; vfmt[8]  = 3'd1; vill[8]  = 1'b0; // srai x1,x1,31
        vin[9]  = 32'hFE512A23; vimm[9]  = 32'hFFFFFFF4; vfmt[9]  = 3'd2; vill[9]  = 1'b0; // sw x5,-12(x2)
        vin[10] = 32'h003100B3; vimm[10] = 32'h0;        vfmt[10] = 3'd6; vill[10] = 1'b0; // add
        vin[11] = 32'h0FF0000F; vimm[11] = 32'h0;        vfmt[11] = 3'd0; vill[11] = 1'b0; // fence
        vin[12] = 32'h300FD0F3; vimm[12] = zimm;         vfmt[12] = zfmt; vill[12] = 1'b0; // csrrwi
        vin[13] = 32'h0000001B; vimm[13] = 32'h0;        vfmt[13] = 3'd0; vill[13] = 1'b1; // OP-IMM-32 on RV32
        vin[14] = 32'hFFFFF117; vimm[14] = 32'hFFFFF000; vfmt[14] = 3'd4; vill[14] = 1'b0; // auipc
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_instr = vin[i];
            in_pc    = 32'h1000 + 32'(i * 4);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_imm !== vimm[i] || out_fmt !== vfmt[i] ||
                out_illegal !== vill[i] || out_instr !== vin[i] || out_pc !== 32'h1000 + 32'(i * 4)) begin
                errors++;
                $display("FAIL fmt[%0d] %h: valid=%b imm=%h fmt=%0d ill=%b instr=%h pc=%h, want valid=1 imm=%h fmt=%0d ill=%b pc=%h",
                         i, vin[i], out_valid, out_imm, out_fmt, out_illegal, out_instr, out_pc,
                         vimm[i], vfmt[i], vill[i], 32'h1000 + 32'(i * 4));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_idle: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    // Fill output with A and skid with B while out_ready is low.
    task automatic fill_stall(input logic [31:0] a, input logic [31:0] b);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = a; in_pc = 32'hA0;
        tick();
        in_instr  = b; in_pc = 32'hB0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa, wb, wc;
        wa = 32'hFFC12083; wb = 32'h123452B7; wc = 32'h001000EF;
        fill_stall(wa, wb);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== wa || out_imm !== 32'hFFFFFFFC || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL skid_fill: valid=%b instr=%h imm=%h ready=%b, want 1 %h fffffffc 0",
                     out_valid, out_instr, out_imm, in_ready, wa);
        end
        in_instr = wc; in_pc = 32'hC0;
        tick();
        checks++;
        if (out_instr !== wa || out_pc !== 32'hA0 || out_fmt !== 3'd1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: instr=%h pc=%h fmt=%0d ready=%b, want %h a0 1 0",
                     out_instr, out_pc, out_fmt, in_ready, wa);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_instr !== wb || out_imm !== 32'h12345000 || out_pc !== 32'hB0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_b: valid=%b instr=%h imm=%h pc=%h ready=%b, want 1 %h 12345000 b0 1",
                     out_valid, out_instr, out_imm, out_pc, in_ready, wb);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_instr !== wc || out_imm !== 32'h00000800 || out_pc !== 32'hC0) begin
            errors++;
            $display("FAIL drain_c: valid=%b instr=%h imm=%h pc=%h, want 1 %h 00000800 c0",
                     out_valid, out_instr, out_imm, out_pc, wc);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: valid=%b, want 0 (no duplicate)", out_valid);
        end
    endtask

    task automatic test_flush();
        fill_stall(32'hFFC12083, 32'h123452B7);
        flush    = 1'b1;
        in_instr = 32'h001000EF;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_stall: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: valid=%b, want 0", out_valid);
        end
        // flush wins over a simultaneous accept and drain
        in_valid = 1'b1; in_instr = 32'h00309093;
        tick();
        flush = 1'b1; in_instr = 32'h003100B3;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        fill_stall(32'hFE512A23, 32'h41F0D093);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== '0 || out_imm !== '0) begin
            errors++;
            $display("FAIL reset_mid_stall: valid=%b ready=%b instr=%h imm=%h, want 0 1 0 0",
                     out_valid, in_ready, out_instr, out_imm);
        end
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_residue: valid=%b, want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
